// File: rtl/ctrl_sched_pkg.sv
// rtl/ctrl_sched_pkg.sv - shared types and defaults for the controller poll scheduler
// Purpose: scheduler state encoding, default parameter values and a width helper.
// Contents: state_e, DEF_POLL_PERIOD, DEF_TIMEOUT, DEF_MAX_RETRY, clog2_min1().
package ctrl_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RECOVER,
        NEXT
    } state_e;

    localparam int DEF_POLL_PERIOD = 50000;
    localparam int DEF_TIMEOUT     = 20000;
    localparam int DEF_MAX_RETRY   = 2;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_sched_tick.sv
// rtl/ctrl_sched_tick.sv - enable-gated poll period counter producing the round tick
// Purpose: counts 0..POLL_PERIOD-1 while enabled, held at 0 while disabled.
// Ports: clk_i clock, rst_i sync active-high reset, enable_i run the counter,
//        tick_o high while the count sits on its last value.
module ctrl_sched_tick
    import ctrl_sched_pkg::*;
#(
    parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int             CW   = clog2_min1(POLL_PERIOD);
    localparam logic [CW-1:0]  LAST = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/controller_poll_sched.sv
// rtl/controller_poll_sched.sv - shares one controller_io engine between NUM_PORTS connectors
// Purpose: every POLL_PERIOD clocks start one poll per port in order, steer the
//          external mux with port_sel, recover the engine from ERROR with eng_rst and
//          retry up to MAX_RETRY extra times, and report per-port valid/fault status.
// Optional: define CTRL_SCHED_TIMEOUT_EN to bound WAIT_BUSY/WAIT_DONE to TIMEOUT clocks.
// Ports: clk, rst (sync active-high), enable, eng_att (1 = engine idle), eng_err,
//        eng_start/eng_rst one-cycle engine pulses, port_sel active connector,
//        port_valid/port_fault per-port status, round_done end-of-round pulse,
//        overrun sticky flag for a tick that arrived mid-round.
module controller_poll_sched
    import ctrl_sched_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                eng_att,
    input  logic                                eng_err,
    output logic                                eng_start,
    output logic                                eng_rst,
    output logic [clog2_min1(NUM_PORTS)-1:0]    port_sel,
    output logic [NUM_PORTS-1:0]                port_valid,
    output logic [NUM_PORTS-1:0]                port_fault,
    output logic                                round_done,
    output logic                                overrun
);

    localparam int             SW       = clog2_min1(NUM_PORTS);
    localparam int             RW       = clog2_min1(MAX_RETRY + 1);
    localparam logic [SW-1:0]  LAST_SEL = SW'(NUM_PORTS - 1);
    localparam logic [RW-1:0]  RETRIES  = RW'(MAX_RETRY);

    if (NUM_PORTS < 1 || NUM_PORTS > 4 || POLL_PERIOD < 1 || TIMEOUT < 1 || MAX_RETRY < 0)
    begin : g_param_check
        $error("controller_poll_sched: parameter out of range");
    end

    state_e                 state_q, state_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic [NUM_PORTS-1:0]   valid_q, valid_d;
    logic [NUM_PORTS-1:0]   fault_q, fault_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic                   overrun_q, overrun_d;
    logic                   tick;
    logic                   timed_out;

`ifdef CTRL_SCHED_TIMEOUT_EN
    localparam int             TW     = clog2_min1(TIMEOUT);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]          timer_q, timer_d;
    // Asserted on the TIMEOUT-th cycle spent in the current wait state.
    assign timed_out = (timer_q == T_LAST);
`else
    assign timed_out = 1'b0;
`endif

    ctrl_sched_tick #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_tick (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .tick_o   (tick)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        retry_d    = retry_q;
        overrun_d  = overrun_q;
        eng_start  = 1'b0;
        eng_rst    = 1'b0;
        round_done = 1'b0;
`ifdef CTRL_SCHED_TIMEOUT_EN
        timer_d    = timer_q + TW'(1);
`endif

        // A tick while a round is still running is dropped, only remembered here.
        if (tick && state_q != IDLE && state_q != WAIT_TICK) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = LAUNCH;
                    sel_d   = '0;
                    retry_d = '0;
                end
            end
            LAUNCH: begin
                eng_start = 1'b1;
                state_d   = WAIT_BUSY;
`ifdef CTRL_SCHED_TIMEOUT_EN
                timer_d   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (eng_err) begin
                    state_d = RECOVER;
                end else if (!eng_att) begin
                    state_d = WAIT_DONE;
`ifdef CTRL_SCHED_TIMEOUT_EN
                    timer_d = '0;
`endif
                end else if (timed_out) begin
                    state_d = RECOVER;
                end
            end
            WAIT_DONE: begin
                // The engine raises err and att together on failure; err wins.
                if (eng_err) begin
                    state_d = RECOVER;
                end else if (eng_att) begin
                    valid_d[sel_q] = 1'b1;
                    fault_d[sel_q] = 1'b0;
                    retry_d        = '0;
                    state_d        = NEXT;
                end else if (timed_out) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                eng_rst = 1'b1;
                if (retry_q < RETRIES) begin
                    retry_d = retry_q + RW'(1);
                    state_d = LAUNCH;
                end else begin
                    fault_d[sel_q] = 1'b1;
                    valid_d[sel_q] = 1'b0;
                    retry_d        = '0;
                    state_d        = NEXT;
                end
            end
            NEXT: begin
                if (sel_q == LAST_SEL) begin
                    round_done = 1'b1;
                    sel_d      = '0;
                    state_d    = enable ? WAIT_TICK : IDLE;
                end else begin
                    sel_d   = sel_q + SW'(1);
                    retry_d = '0;
                    state_d = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            valid_q   <= '0;
            fault_q   <= '0;
            retry_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            retry_q   <= retry_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef CTRL_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign port_sel   = sel_q;
    assign port_valid = valid_q;
    assign port_fault = fault_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_controller_poll_sched.sv
// tb/tb_controller_poll_sched.sv - randomized self-checking bench for controller_poll_sched
module tb_controller_poll_sched;

    localparam int NP = 2;
    localparam int P  = 100;
    localparam int TO = 200;
    localparam int MR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          eng_att = 1'b1;
    logic          eng_err = 1'b0;
    logic          eng_start, eng_rst, round_done, overrun;
    logic [0:0]    port_sel;
    logic [NP-1:0] port_valid, port_fault;

    controller_poll_sched #(
        .NUM_PORTS   (NP),
        .POLL_PERIOD (P),
        .TIMEOUT     (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .eng_att    (eng_att),
        .eng_err    (eng_err),
        .eng_start  (eng_start),
        .eng_rst    (eng_rst),
        .port_sel   (port_sel),
        .port_valid (port_valid),
        .port_fault (port_fault),
        .round_done (round_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int      m_cnt = 0;
    int      m_sel = 0;
    bit [NP-1:0] m_valid = '0, m_fault = '0;
    bit      m_ovr = 0, m_start = 0, m_rst = 0, m_done = 0;
    bit      m_in_round = 0, rst_seen = 0;
    bit      s_en, s_att, s_err, s_tick;

    // Advance one clock edge and apply the edge's global effects.
    task automatic step();
        bit prev_tick;
        @(posedge clk);
        s_en = enable; s_att = eng_att; s_err = eng_err;
        prev_tick = (m_cnt == P - 1);
        m_start = 0; m_rst = 0; m_done = 0;
        if (rst) begin
            m_cnt = 0; rst_seen = 1; m_sel = 0; m_valid = '0; m_fault = '0;
            m_ovr = 0; m_in_round = 0; s_tick = 0;
        end else begin
            if (prev_tick && m_in_round) m_ovr = 1;
            m_cnt = enable ? (m_cnt + 1) % P : 0;
            s_tick = prev_tick;
        end
    endtask

    // One whole round: each port gets up to MR+1 attempts.
    task automatic poll_round(output bit cont);
        cont = 0;
        m_in_round = 1;
        for (int p = 0; p < NP; p++) begin
            bit ok;
            ok = 0;
            m_sel = p;
            for (int a = 0; a <= MR && !ok; a++) begin
                int n;
                bit failed;
                m_start = 1;
                step(); if (rst_seen) return;
                failed = 0; n = 0;
                forever begin
                    step(); if (rst_seen) return;
                    n++;
                    if (s_err) begin failed = 1; break; end
                    if (!s_att) break;
`ifdef CTRL_SCHED_TIMEOUT_EN
                    if (n == TO) begin failed = 1; break; end
`endif
                end
                if (!failed) begin
                    n = 0;
                    forever begin
                        step(); if (rst_seen) return;
                        n++;
                        if (s_err) begin failed = 1; break; end
                        if (s_att) break;
`ifdef CTRL_SCHED_TIMEOUT_EN
                        if (n == TO) begin failed = 1; break; end
`endif
                    end
                end
                if (!failed) begin
                    ok = 1; m_valid[p] = 1; m_fault[p] = 0;
                end else begin
                    m_rst = 1;
                    step(); if (rst_seen) return;
                    if (a == MR) begin m_fault[p] = 1; m_valid[p] = 0; end
                end
            end
            if (p == NP - 1) m_done = 1;
            step(); if (rst_seen) return;
            if (p == NP - 1) begin m_sel = 0; cont = s_en; end
        end
        m_in_round = 0;
    endtask

    task automatic wait_tick_loop();
        bit go_on;
        go_on = 1;
        while (go_on) begin
            step();
            if (rst_seen || !s_en) go_on = 0;
            else if (s_tick) poll_round(go_on);
        end
    endtask

    initial begin : model
        forever begin
            rst_seen = 0;
            m_in_round = 0;
            step();
            if (!rst_seen && s_en) wait_tick_loop();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_on = 0;
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("eng_start",  int'(eng_start),  int'(m_start));
                chk("eng_rst",    int'(eng_rst),    int'(m_rst));
                chk("port_sel",   int'(port_sel),   m_sel);
                chk("port_valid", int'(port_valid), int'(m_valid));
                chk("port_fault", int'(port_fault), int'(m_fault));
                chk("round_done", int'(round_done), int'(m_done));
                chk("overrun",    int'(overrun),    int'(m_ovr));
            end
        end
    end

    // ---------------- engine stub ----------------
    int fails_left [NP];
    int busy_max = 3, low_min = 20, low_max = 20;
    initial begin : engine
        int  e_ph, e_cnt;
        bit  e_fail;
        e_ph = 0; e_cnt = 0; e_fail = 0;
        for (int i = 0; i < NP; i++) fails_left[i] = 0;
        forever begin
            @(negedge clk);
            if (rst || eng_rst) begin
                e_ph = 0; eng_att = 1; eng_err = 0;
            end else if (eng_start) begin
                e_fail = fails_left[port_sel] > 0;
                if (e_fail) fails_left[port_sel]--;
                e_cnt = $urandom_range(busy_max, 1);
                e_ph = 1;
            end else if (e_ph == 1) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    if (e_fail) begin
                        eng_err = 1; eng_att = 1; e_ph = 3;
                    end else begin
                        eng_att = 0; e_cnt = $urandom_range(low_max, low_min); e_ph = 2;
                    end
                end
            end else if (e_ph == 2) begin
                e_cnt--;
                if (e_cnt == 0) begin eng_att = 1; e_ph = 0; end
            end
        end
    end

    // ---------------- pulse counters ----------------
    int n_start [NP];
    int n_rstp  [NP];
    int n_done = 0, starts_since_done = 0;
    initial begin : monitor
        for (int i = 0; i < NP; i++) begin n_start[i] = 0; n_rstp[i] = 0; end
        forever begin
            @(negedge clk);
            if (eng_start) begin n_start[port_sel]++; starts_since_done++; end
            if (eng_rst) n_rstp[port_sel]++;
            if (round_done) begin n_done++; starts_since_done = 0; end
        end
    end

    task automatic phase_reset();
        enable = 0; rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(port_valid), 0);
        chk("rst_fault", int'(port_fault), 0);
        chk("rst_ovr",   int'(overrun), 0);
        chk("rst_sel",   int'(port_sel), 0);
        chk("rst_start", int'(eng_start | eng_rst | round_done), 0);
        for (int i = 0; i < NP; i++) begin n_start[i] = 0; n_rstp[i] = 0; fails_left[i] = 0; end
        n_done = 0; starts_since_done = 0;
        rst = 0; enable = 1;
    endtask

    initial begin : main
        int done_at_drop;
        repeat (3) @(negedge clk);
        cmp_on = 1;

        // all ports succeed, 20-cycle ATT-low window
        phase_reset();
        repeat (390) @(negedge clk);
        chk("p1_valid", int'(port_valid), 3);
        chk("p1_fault", int'(port_fault), 0);
        chk("p1_ovr",   int'(overrun), 0);
        chk("p1_done",  n_done, 3);
        chk("p1_start0", n_start[0], 3);
        chk("p1_start1", n_start[1], 3);

        // port 1 fails every attempt
        phase_reset();
        fails_left[1] = 1000;
        repeat (390) @(negedge clk);
        chk("p2_fault", int'(port_fault), 2);
        chk("p2_valid", int'(port_valid), 1);
        chk("p2_start1", n_start[1], 9);
        chk("p2_rst1",   n_rstp[1], 9);
        chk("p2_done",   n_done, 3);

        // port 0 fails once then succeeds
        phase_reset();
        fails_left[0] = 1;
        repeat (390) @(negedge clk);
        chk("p3_start0", n_start[0], 4);
        chk("p3_rst0",   n_rstp[0], 1);
        chk("p3_valid",  int'(port_valid), 3);
        chk("p3_fault",  int'(port_fault), 0);

        // rounds longer than the period
        phase_reset();
        low_min = 80; low_max = 80;
        repeat (390) @(negedge clk);
        chk("p4_ovr",  int'(overrun), 1);
        chk("p4_done", n_done, 1);

        // randomized configurations
        for (int r = 0; r < 4; r++) begin
            phase_reset();
            busy_max = $urandom_range(4, 1);
            low_min = $urandom_range(10, 1);
            low_max = low_min + $urandom_range(20, 0);
            for (int i = 0; i < NP; i++) fails_left[i] = $urandom_range(4, 0);
            repeat (390) @(negedge clk);
        end

        // reset mid-WAIT_DONE, then enable dropped mid-round
        phase_reset();
        busy_max = 3; low_min = 20; low_max = 20;
        repeat (110) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("p6_rst_valid", int'(port_valid), 0);
        chk("p6_rst_sel",   int'(port_sel), 0);
        chk("p6_rst_pulse", int'(eng_start | eng_rst | round_done | overrun), 0);
        rst = 0;
        repeat (105) @(negedge clk);
        done_at_drop = n_done;
        enable = 0;
        repeat (200) @(negedge clk);
        chk("p6_drop_done",   n_done - done_at_drop, 1);
        chk("p6_drop_starts", starts_since_done, 0);
        chk("p6_drop_valid",  int'(port_valid), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_poll_sched.md
Name: controller_poll_sched

Overview:
Scheduler that shares one controller_io serial engine between NUM_PORTS controller connectors.
- Issues a poll round every POLL_PERIOD clocks: one start per port, in order.
- Drives port_sel so the external mux routes ATT/DATA/ACK to the active connector.
- Recovers the engine from its sticky ERROR state by pulsing eng_rst, retries, and reports per-port valid/fault status to game logic.

Parameters:
NUM_PORTS, 2, number of connectors sharing the engine (1..4)
POLL_PERIOD, 50000, clocks between round starts
TIMEOUT, 20000, max clocks allowed in WAIT_BUSY or WAIT_DONE (used only with the optional feature)
MAX_RETRY, 2, extra attempts per port after a failure

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  polling enabled
eng_att  input  1  engine ATT output; 1 = engine idle
eng_err  input  1  engine err output
eng_start  output  1  one-cycle start pulse to engine
eng_rst  output  1  one-cycle reset pulse to engine
port_sel  output  $clog2(NUM_PORTS) (min 1)  active connector index
port_valid  output  NUM_PORTS  port holds data from a successful poll
port_fault  output  NUM_PORTS  port exhausted its retries in the last attempt
round_done  output  1  one-cycle pulse at end of each round
overrun  output  1  sticky; a tick arrived mid-round

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: state IDLE, period counter 0, eng_start 0, eng_rst 0, port_sel 0, port_valid 0, port_fault 0, round_done 0, overrun 0, retry 0.
- Period counter:
  - Runs while enable=1, from 0 to POLL_PERIOD-1, then wraps.
  - tick = (count == POLL_PERIOD-1).
  - Cleared when enable=0.
- States:
  - IDLE: on enable=1 -> WAIT_TICK.
  - WAIT_TICK:
    - enable=0 -> IDLE.
    - tick -> LAUNCH with port_sel=0, retry=0.
  - LAUNCH: eng_start=1 for this cycle only -> WAIT_BUSY; clear the state timer.
  - WAIT_BUSY:
    - eng_err=1 -> RECOVER (err has priority).
    - else eng_att=0 -> WAIT_DONE; clear the state timer.
  - WAIT_DONE:
    - eng_err=1 -> RECOVER (err has priority over eng_att=1; the engine raises both together on error).
    - else eng_att=1 -> success: port_valid[sel]<=1, port_fault[sel]<=0, retry<=0 -> NEXT.
  - RECOVER: eng_rst=1 for this cycle only.
    - retry<MAX_RETRY -> retry+1 -> LAUNCH.
    - else port_fault[sel]<=1, port_valid[sel]<=0, retry<=0 -> NEXT.
  - NEXT:
    - sel==NUM_PORTS-1 -> round_done=1, port_sel<=0, then WAIT_TICK if enable=1, else IDLE.
    - else port_sel+1, retry<=0 -> LAUNCH.
- port_sel changes only in NEXT and reset; it is stable from LAUNCH through RECOVER.
- tick in any state other than WAIT_TICK/IDLE: sets overrun<=1 (sticky until rst); the tick is dropped, not queued.
- enable deasserted mid-round: the round completes; NEXT on the last port goes to IDLE.
- eng_start and eng_rst are never asserted in the same cycle.
- Retry counter width: $clog2(MAX_RETRY+1), min 1.

Optional Feature:
CTRL_SCHED_TIMEOUT_EN
- Defined:
  - A state timer counts cycles in WAIT_BUSY and WAIT_DONE, cleared on entry to each.
  - Reaching TIMEOUT with no exit condition -> RECOVER; this counts as a failure.
  - Covers unplugged controllers that never drop ATT or never ACK.
- Undefined: no timer logic; both states wait indefinitely for eng_att/eng_err.

Decomposition:
- Package ctrl_sched_pkg holds:
  - state enum (IDLE, WAIT_TICK, LAUNCH, WAIT_BUSY, WAIT_DONE, RECOVER, NEXT)
  - default constants for POLL_PERIOD, TIMEOUT, MAX_RETRY
- One sub-module, ctrl_sched_tick: enable-gated period counter producing tick. The FSM stays in the top.

Test Plan:
1. NUM_PORTS=2, POLL_PERIOD=100, engine model completes each poll with a 20-cycle ATT-low window -> eng_start pulses with port_sel=0 then 1; port_valid=2'b11; round_done pulses once per 100 clocks; overrun=0.
2. Port 1 model raises err with ATT=1 on every attempt, MAX_RETRY=2 -> 3 eng_start and 3 eng_rst pulses on port 1; port_fault=2'b10; port_valid=2'b01; round_done still pulses.
3. Port 0 fails once, then succeeds -> 1 eng_rst, 2 eng_start on port 0; port_fault[0]=0; port_valid[0]=1.
4. POLL_PERIOD=30 with a 40-cycle poll -> overrun=1 after the first tick lands mid-round; the following round starts only on a tick seen in WAIT_TICK.
5. With CTRL_SCHED_TIMEOUT_EN, TIMEOUT=50, eng_att held 1 after start -> RECOVER 50 cycles after entering WAIT_BUSY; after retries, port_fault[sel]=1.
6. Assert rst mid-WAIT_DONE; also drop enable mid-round -> after rst, all outputs return to reset values next cycle; on enable drop, the round finishes, round_done pulses, then state IDLE with no further eng_start.
